// File: rtl/ulpi_phy_reg_responder_if.sv
// ULPI PHY register-access bus: link-driven data/stp plus PHY-driven data/dir/nxt and write report.
// Latency: none (wires only).
// Backpressure: the PHY paces the link with nxt; the link can only abort with stp.
// Ports (signals): ulpi_data_i/ulpi_stp from the link; ulpi_data_o/ulpi_data_oe/ulpi_dir/ulpi_nxt
//                  from the PHY; reg_wr_stb/reg_wr_addr/reg_wr_data report committed writes.
interface ulpi_phy_reg_responder_if;
  logic [7:0] ulpi_data_i;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       reg_wr_stb;
  logic [5:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  // Link side: drives the bus and stp, observes everything the PHY returns.
  modport master (
    output ulpi_data_i, ulpi_stp,
    input  ulpi_data_o, ulpi_data_oe, ulpi_dir, ulpi_nxt,
    input  reg_wr_stb, reg_wr_addr, reg_wr_data
  );

  // PHY side: this responder.
  modport slave (
    input  ulpi_data_i, ulpi_stp,
    output ulpi_data_o, ulpi_data_oe, ulpi_dir, ulpi_nxt,
    output reg_wr_stb, reg_wr_addr, reg_wr_data
  );
endinterface

// File: rtl/ulpi_phy_reg_responder.sv
// PHY-side ULPI register responder: decodes link TX CMDs and serves reads/writes from a small register file.
// Latency: TX CMD to nxt = NXT_DELAY+1 cycles, TX CMD to read data = NXT_DELAY+3 cycles; write strobe 1 cycle after stp.
// Backpressure: nxt paces the link; stp aborts before data is accepted, is ignored during reads, and WR_STP waits for it forever.
// Ports: clk, reset (async, active-high); ulpi (slave modport) carrying the ULPI data/stp/dir/nxt
//        signals, the data output enable, and the committed-write report (stb/addr/data).
module ulpi_phy_reg_responder #(
  parameter int          REG_COUNT  = 16,
  parameter int          NXT_DELAY  = 0,
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input logic                     clk,
  input logic                     reset,
  ulpi_phy_reg_responder_if.slave ulpi
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_WAIT,
    CMD_ACK,
    RD_TURN1,
    RD_DATA,
    RD_TURN2,
    WR_DATA,
    WR_STP
  } state_t;

  typedef logic [63:0][7:0] regfile_t;

  localparam logic [6:0] REG_LIMIT = 7'(REG_COUNT);
  // CMD_WAIT counts down to zero, so it is loaded with one less than the delay.
  localparam logic [3:0] WAIT_INIT = 4'((NXT_DELAY > 0) ? (NXT_DELAY - 1) : 0);

  function automatic regfile_t init_regs();
    regfile_t r;
    r    = '0;
    r[0] = VENDOR_ID[7:0];
    r[1] = VENDOR_ID[15:8];
    r[2] = PRODUCT_ID[7:0];
    r[3] = PRODUCT_ID[15:8];
    return r;
  endfunction

  localparam regfile_t REG_INIT = init_regs();

  state_t     state;
  logic [5:0] addr;
  logic       is_rd;
  logic [3:0] wait_cnt;
  logic [7:0] wr_latch;

  // Full 64-entry address space; entries at or above REG_COUNT are never
  // written, so they stay zero and reads of them naturally return 8'h00.
  regfile_t   regs;

  logic [5:0] cmd_addr;
  logic       cmd_go;
  logic       wr_commit;
  logic       wr_allowed;

  assign cmd_addr   = ulpi.ulpi_data_i[5:0];
  // Bit 7 set means register write (10) or read (11); 6'h2F is the extended
  // register escape, which this model does not implement.
  assign cmd_go     = ulpi.ulpi_data_i[7] && (cmd_addr != 6'h2F);
  assign wr_commit  = (state == WR_STP) && ulpi.ulpi_stp;
  // ID registers are read-only; out-of-range writes are handshaken and reported but dropped.
  assign wr_allowed = (addr >= 6'd4) && ({1'b0, addr} < REG_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= REG_INIT;
    end else if (wr_commit && wr_allowed) begin
      regs[addr] <= wr_latch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      addr              <= '0;
      is_rd             <= 1'b0;
      wait_cnt          <= '0;
      wr_latch          <= '0;
      ulpi.ulpi_data_o  <= '0;
      ulpi.ulpi_data_oe <= 1'b0;
      ulpi.ulpi_dir     <= 1'b0;
      ulpi.ulpi_nxt     <= 1'b0;
      ulpi.reg_wr_stb   <= 1'b0;
      ulpi.reg_wr_addr  <= '0;
      ulpi.reg_wr_data  <= '0;
    end else begin
      // Outputs default to the idle bus; each state below re-asserts what the
      // next state needs, so every output is a registered function of state.
      ulpi.ulpi_data_o  <= '0;
      ulpi.ulpi_data_oe <= 1'b0;
      ulpi.ulpi_dir     <= 1'b0;
      ulpi.ulpi_nxt     <= 1'b0;
      ulpi.reg_wr_stb   <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_go) begin
            addr  <= cmd_addr;
            is_rd <= ulpi.ulpi_data_i[6];
            if (NXT_DELAY == 0) begin
              state         <= CMD_ACK;
              ulpi.ulpi_nxt <= 1'b1;
            end else begin
              state    <= CMD_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        CMD_WAIT: begin
          if (ulpi.ulpi_stp) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state         <= CMD_ACK;
            ulpi.ulpi_nxt <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        CMD_ACK: begin
          if (ulpi.ulpi_stp) begin
            state <= IDLE;
          end else if (is_rd) begin
            state         <= RD_TURN1;
            ulpi.ulpi_dir <= 1'b1;
          end else begin
            state         <= WR_DATA;
            ulpi.ulpi_nxt <= 1'b1;
          end
        end

        // Read turnaround: dir rises one cycle before we drive the bus.
        RD_TURN1: begin
          state             <= RD_DATA;
          ulpi.ulpi_dir     <= 1'b1;
          ulpi.ulpi_data_oe <= 1'b1;
          ulpi.ulpi_data_o  <= regs[addr];
        end

        RD_DATA: begin
          state <= RD_TURN2;
        end

        RD_TURN2: begin
          state <= IDLE;
        end

        WR_DATA: begin
          if (ulpi.ulpi_stp) begin
            state <= IDLE;
          end else begin
            state    <= WR_STP;
            wr_latch <= ulpi.ulpi_data_i;
          end
        end

        WR_STP: begin
          if (ulpi.ulpi_stp) begin
            state            <= IDLE;
            ulpi.reg_wr_stb  <= 1'b1;
            ulpi.reg_wr_addr <= addr;
            ulpi.reg_wr_data <= wr_latch;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_phy_reg_responder.sv
// Bench for ulpi_phy_reg_responder: two instances (NXT_DELAY 0 and 2) driven as a ULPI link.
// Latency: expected read data and write reports are queued at stimulus time, checked on DUT output.
// Backpressure: stimulus follows nxt timing cycle by cycle; stp used for commit and abort.
module tb_ulpi_phy_reg_responder;

  logic clk = 1'b0;
  logic rst0;
  logic rst2;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rdq0[$];
  logic [7:0]  rdq2[$];
  logic [13:0] wrq0[$];
  logic [13:0] wrq2[$];

  ulpi_phy_reg_responder_if bus0 ();
  ulpi_phy_reg_responder_if bus2 ();

  ulpi_phy_reg_responder #(
    .REG_COUNT (16),
    .NXT_DELAY (0),
    .VENDOR_ID (16'h0424),
    .PRODUCT_ID(16'h0009)
  ) dut0 (
    .clk  (clk),
    .reset(rst0),
    .ulpi (bus0)
  );

  ulpi_phy_reg_responder #(
    .REG_COUNT (16),
    .NXT_DELAY (2),
    .VENDOR_ID (16'h0424),
    .PRODUCT_ID(16'h0009)
  ) dut2 (
    .clk  (clk),
    .reset(rst2),
    .ulpi (bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: compare against the scoreboard queues mid-cycle.
  always @(negedge clk) begin
    if (!rst0) begin
      if (bus0.ulpi_data_oe) begin
        chk("rd0_pending", 32'(rdq0.size() > 0), 1);
        if (rdq0.size() > 0) chk("rd0_data", 32'(bus0.ulpi_data_o), 32'(rdq0.pop_front()));
      end else begin
        chk("rd0_idle_data", 32'(bus0.ulpi_data_o), 0);
      end
      if (bus0.reg_wr_stb) begin
        chk("wr0_pending", 32'(wrq0.size() > 0), 1);
        if (wrq0.size() > 0) chk("wr0_report", 32'({bus0.reg_wr_addr, bus0.reg_wr_data}), 32'(wrq0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst2) begin
      if (bus2.ulpi_data_oe) begin
        chk("rd2_pending", 32'(rdq2.size() > 0), 1);
        if (rdq2.size() > 0) chk("rd2_data", 32'(bus2.ulpi_data_o), 32'(rdq2.pop_front()));
      end else begin
        chk("rd2_idle_data", 32'(bus2.ulpi_data_o), 0);
      end
      if (bus2.reg_wr_stb) begin
        chk("wr2_pending", 32'(wrq2.size() > 0), 1);
        if (wrq2.size() > 0) chk("wr2_report", 32'({bus2.reg_wr_addr, bus2.reg_wr_data}), 32'(wrq2.pop_front()));
      end
    end
  end

  // Read on dut0 starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic rd0(input logic [5:0] a, input logic [7:0] exp);
    rdq0.push_back(exp);
    bus0.ulpi_data_i = {2'b11, a};
    tick();
    bus0.ulpi_data_i = 8'h00;
    chk("rd0_ack_nxt", 32'(bus0.ulpi_nxt), 1);
    chk("rd0_ack_dir", 32'(bus0.ulpi_dir), 0);
    tick();
    chk("rd0_turn1_dir", 32'(bus0.ulpi_dir), 1);
    chk("rd0_turn1_oe", 32'(bus0.ulpi_data_oe), 0);
    chk("rd0_turn1_nxt", 32'(bus0.ulpi_nxt), 0);
    tick();
    chk("rd0_data_dir", 32'(bus0.ulpi_dir), 1);
    chk("rd0_data_oe", 32'(bus0.ulpi_data_oe), 1);
    tick();
    chk("rd0_turn2_dir", 32'(bus0.ulpi_dir), 0);
    chk("rd0_turn2_oe", 32'(bus0.ulpi_data_oe), 0);
    tick();
  endtask

  // Write on dut0; stp_wait extra cycles are spent in WR_STP before stp.
  task automatic wr0(input logic [5:0] a, input logic [7:0] d, input int stp_wait);
    wrq0.push_back({a, d});
    bus0.ulpi_data_i = {2'b10, a};
    tick();
    chk("wr0_ack_nxt", 32'(bus0.ulpi_nxt), 1);
    tick();
    chk("wr0_data_nxt", 32'(bus0.ulpi_nxt), 1);
    bus0.ulpi_data_i = d;
    tick();
    bus0.ulpi_data_i = 8'h00;
    chk("wr0_stp_nxt", 32'(bus0.ulpi_nxt), 0);
    for (int i = 0; i < stp_wait; i++) begin
      tick();
      chk("wr0_hold_stb", 32'(bus0.reg_wr_stb), 0);
    end
    bus0.ulpi_stp = 1'b1;
    tick();
    bus0.ulpi_stp = 1'b0;
    chk("wr0_stb_pulse", 32'(bus0.reg_wr_stb), 1);
    tick();
    chk("wr0_stb_clear", 32'(bus0.reg_wr_stb), 0);
  endtask

  // Read on dut2 (two wait cycles before nxt).
  task automatic rd2(input logic [5:0] a, input logic [7:0] exp);
    rdq2.push_back(exp);
    bus2.ulpi_data_i = {2'b11, a};
    tick();
    bus2.ulpi_data_i = 8'h00;
    chk("rd2_wait1_nxt", 32'(bus2.ulpi_nxt), 0);
    tick();
    chk("rd2_wait2_nxt", 32'(bus2.ulpi_nxt), 0);
    tick();
    chk("rd2_ack_nxt", 32'(bus2.ulpi_nxt), 1);
    tick();
    chk("rd2_turn1_dir", 32'(bus2.ulpi_dir), 1);
    chk("rd2_turn1_oe", 32'(bus2.ulpi_data_oe), 0);
    tick();
    chk("rd2_data_oe", 32'(bus2.ulpi_data_oe), 1);
    tick();
    chk("rd2_turn2_dir", 32'(bus2.ulpi_dir), 0);
    tick();
  endtask

  logic [7:0] ignored_cmds[5];

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    bus0.ulpi_data_i = 8'h00;
    bus0.ulpi_stp    = 1'b0;
    bus2.ulpi_data_i = 8'h00;
    bus2.ulpi_stp    = 1'b0;
    ignored_cmds[0] = 8'h00;
    ignored_cmds[1] = 8'h41;
    ignored_cmds[2] = 8'h6F;
    ignored_cmds[3] = 8'hEF;
    ignored_cmds[4] = 8'hAF;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_data_o", 32'(bus0.ulpi_data_o), 0);
    chk("rst_oe", 32'(bus0.ulpi_data_oe), 0);
    chk("rst_dir", 32'(bus0.ulpi_dir), 0);
    chk("rst_nxt", 32'(bus0.ulpi_nxt), 0);
    chk("rst_stb", 32'(bus0.reg_wr_stb), 0);
    chk("rst_wr_addr", 32'(bus0.reg_wr_addr), 0);
    chk("rst_wr_data", 32'(bus0.reg_wr_data), 0);
    chk("rst2_dir", 32'(bus2.ulpi_dir), 0);

    rst0 = 1'b0;
    rst2 = 1'b0;
    tick();

    // ID registers, back-to-back with no idle gap.
    rd0(6'h01, 8'h04);
    rd0(6'h00, 8'h24);
    rd0(6'h02, 8'h09);
    rd0(6'h03, 8'h00);

    // Plain write and readback.
    wr0(6'h05, 8'h5A, 0);
    rd0(6'h05, 8'h5A);

    // Read-only ID register: strobe reported, value kept.
    wr0(6'h00, 8'hFF, 0);
    rd0(6'h00, 8'h24);

    // Last implemented register, stp held off a few cycles.
    wr0(6'h0F, 8'hA5, 3);
    rd0(6'h0F, 8'hA5);

    // Out of range: strobe reported, reads as zero.
    wr0(6'h10, 8'h77, 0);
    rd0(6'h10, 8'h00);

    // stp during the nxt cycle of a write aborts it.
    bus0.ulpi_data_i = 8'h86;
    tick();
    chk("abort_ack_nxt", 32'(bus0.ulpi_nxt), 1);
    bus0.ulpi_stp    = 1'b1;
    bus0.ulpi_data_i = 8'h00;
    tick();
    bus0.ulpi_stp = 1'b0;
    chk("abort_idle_nxt", 32'(bus0.ulpi_nxt), 0);
    chk("abort_idle_dir", 32'(bus0.ulpi_dir), 0);
    repeat (2) tick();
    chk("abort_no_stb", 32'(bus0.reg_wr_stb), 0);
    rd0(6'h06, 8'h00);

    // Non-register commands and the extended-address escape are ignored.
    foreach (ignored_cmds[k]) begin
      bus0.ulpi_data_i = ignored_cmds[k];
      tick();
      bus0.ulpi_data_i = 8'h00;
      chk("ignored_nxt1", 32'(bus0.ulpi_nxt), 0);
      tick();
      chk("ignored_nxt2", 32'(bus0.ulpi_nxt), 0);
      chk("ignored_dir", 32'(bus0.ulpi_dir), 0);
    end

    // Reset in the middle of a read drops the bus immediately.
    rdq0.push_back(8'h04);
    bus0.ulpi_data_i = 8'hC1;
    tick();
    bus0.ulpi_data_i = 8'h00;
    tick();
    tick();
    chk("midrst_pre_oe", 32'(bus0.ulpi_data_oe), 1);
    #6;
    rst0 = 1'b1;
    #1;
    chk("midrst_dir", 32'(bus0.ulpi_dir), 0);
    chk("midrst_oe", 32'(bus0.ulpi_data_oe), 0);
    chk("midrst_nxt", 32'(bus0.ulpi_nxt), 0);
    chk("midrst_data_o", 32'(bus0.ulpi_data_o), 0);
    tick();
    rst0 = 1'b0;
    tick();
    rd0(6'h01, 8'h04);
    rd0(6'h05, 8'h00);

    // NXT_DELAY=2 instance.
    rd2(6'h02, 8'h09);
    rd2(6'h0F, 8'h00);

    // stp during the wait cycles aborts the command.
    bus2.ulpi_data_i = 8'hC3;
    tick();
    bus2.ulpi_data_i = 8'h00;
    bus2.ulpi_stp    = 1'b1;
    tick();
    bus2.ulpi_stp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wait_abort_nxt", 32'(bus2.ulpi_nxt), 0);
      chk("wait_abort_dir", 32'(bus2.ulpi_dir), 0);
      tick();
    end
    rd2(6'h00, 8'h24);

    repeat (3) tick();
    chk("rdq0_drained", 32'(rdq0.size()), 0);
    chk("wrq0_drained", 32'(wrq0.size()), 0);
    chk("rdq2_drained", 32'(rdq2.size()), 0);
    chk("wrq2_drained", 32'(wrq2.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
